// File: rtl/phase_monitor_pkg.sv
// Shared types and default parameters for the two-phase clock monitor.
package phase_mon_pkg;

    localparam int CNT_W_DEF       = 9;
    localparam int MIN_HIGH_DEF    = 16;
    localparam int LOCK_CYCLES_DEF = 4;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        P1_HIGH = 3'd1,
        GAP12   = 3'd2,
        P2_HIGH = 3'd3,
        GAP21   = 3'd4
    } state_t;

endpackage

// File: rtl/phase_monitor_if.sv
// Phase inputs, error clear and all monitor status outputs, plus the FSM state for observation.
interface phase_monitor_if import phase_mon_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
);
    // Plain level/strobe signals: no valid/ready handshake, every output is a registered status.
    logic             phi_1;
    logic             phi_2;
    logic             err_clr;
    logic             ph1_rise;
    logic             ph1_fall;
    logic             ph2_rise;
    logic             ph2_fall;
    logic [CNT_W-1:0] ph1_width;
    logic [CNT_W-1:0] ph2_width;
    logic [CNT_W-1:0] period;
    logic             locked;
    logic             overlap_err;
    logic             seq_err;
    logic             width_err;
    state_t           state;

    modport master (
        output phi_1, phi_2, err_clr,
        input  ph1_rise, ph1_fall, ph2_rise, ph2_fall,
        input  ph1_width, ph2_width, period, locked,
        input  overlap_err, seq_err, width_err, state
    );

    modport slave (
        input  phi_1, phi_2, err_clr,
        output ph1_rise, ph1_fall, ph2_rise, ph2_fall,
        output ph1_width, ph2_width, period, locked,
        output overlap_err, seq_err, width_err, state
    );

endinterface

// File: rtl/phase_monitor_edge_detect.sv
// Two-flop sampler for one phase with combinational edge flags and registered one-cycle strobes.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic lvl,
    output logic rise_now,
    output logic fall_now,
    output logic rise,
    output logic fall
);

    logic s;
    logic p;
    logic s_vld;
    logic p_vld;

    // Edges are only trusted once p holds a real sample, so a level already
    // high when reset releases is not reported as a rising edge.
    assign lvl      = s;
    assign rise_now = p_vld & s & ~p;
    assign fall_now = p_vld & ~s & p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s     <= 1'b0;
            p     <= 1'b0;
            s_vld <= 1'b0;
            p_vld <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s     <= d;
            p     <= s;
            s_vld <= 1'b1;
            p_vld <= s_vld;
            rise  <= rise_now;
            fall  <= fall_now;
        end
    end

endmodule

// File: rtl/phase_monitor.sv
// Two-phase clock consumer: edge strobes, ordering/overlap/width checks, width and period
// measurement, and lock detection.
module phase_monitor import phase_mon_pkg::*; #(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MIN_HIGH    = MIN_HIGH_DEF,
    parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    phase_monitor_if.slave  bus
);

    localparam int               LC_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(MIN_HIGH);
    localparam logic [LC_W-1:0]  LOCK_N  = LC_W'(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic s1, s2, r1, f1, r2, f2;
    logic str_r1, str_f1, str_r2, str_f2;
    logic ov, any_edge;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] seg_cnt, per_cnt;
    logic [CNT_W-1:0] ph1_width, ph2_width, period;
    logic [LC_W-1:0]  lock_cnt;
    logic             overlap_err, seq_err, width_err;
    logic             set_ov, set_seq, set_wid, cap1, cap2, done;

    edge_detect u_ed1 (
        .clk(clk), .rst_n(rst_n), .d(bus.phi_1), .lvl(s1),
        .rise_now(r1), .fall_now(f1), .rise(str_r1), .fall(str_f1)
    );

    edge_detect u_ed2 (
        .clk(clk), .rst_n(rst_n), .d(bus.phi_2), .lvl(s2),
        .rise_now(r2), .fall_now(f2), .rise(str_r2), .fall(str_f2)
    );

    assign ov       = s1 & s2;
    assign any_edge = r1 | f1 | r2 | f2;

    // Overlap outranks any edge on the same sample. Zero-gap handovers (one phase
    // falling as the other rises) are legal and skip the gap state entirely.
    always_comb begin
        state_nxt = state;
        set_ov    = 1'b0;
        set_seq   = 1'b0;
        set_wid   = 1'b0;
        cap1      = 1'b0;
        cap2      = 1'b0;
        done      = 1'b0;
        if (ov) begin
            set_ov    = 1'b1;
            state_nxt = HUNT;
        end else begin
            case (state)
                HUNT: begin
                    if (r1) state_nxt = P1_HIGH;
                end
                P1_HIGH: begin
                    if (f1 && !f2) begin
                        cap1 = 1'b1;
                        if (seg_cnt < MIN_W) begin
                            set_wid   = 1'b1;
                            state_nxt = HUNT;
                        end else begin
                            state_nxt = r2 ? P2_HIGH : GAP12;
                        end
                    end else if (any_edge) begin
                        set_seq   = 1'b1;
                        state_nxt = HUNT;
                    end
                end
                GAP12: begin
                    if (r2 && !r1 && !f1) begin
                        state_nxt = P2_HIGH;
                    end else if (any_edge) begin
                        set_seq   = 1'b1;
                        state_nxt = HUNT;
                    end
                end
                P2_HIGH: begin
                    if (f2 && !f1) begin
                        cap2 = 1'b1;
                        if (seg_cnt < MIN_W) begin
                            set_wid   = 1'b1;
                            state_nxt = HUNT;
                        end else begin
                            state_nxt = r1 ? P1_HIGH : GAP21;
                            done      = r1;
                        end
                    end else if (any_edge) begin
                        set_seq   = 1'b1;
                        state_nxt = HUNT;
                    end
                end
                GAP21: begin
                    if (r1 && !r2 && !f2) begin
                        state_nxt = P1_HIGH;
                        done      = 1'b1;
                    end else if (any_edge) begin
                        set_seq   = 1'b1;
                        state_nxt = HUNT;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            seg_cnt     <= '0;
            per_cnt     <= '0;
            ph1_width   <= '0;
            ph2_width   <= '0;
            period      <= '0;
            lock_cnt    <= '0;
            overlap_err <= 1'b0;
            seq_err     <= 1'b0;
            width_err   <= 1'b0;
        end else begin
            state   <= state_nxt;
            seg_cnt <= (state_nxt != state) ? ONE :
                       (seg_cnt == CNT_MAX) ? seg_cnt : seg_cnt + ONE;
            per_cnt <= r1 ? ONE :
                       (per_cnt == CNT_MAX) ? per_cnt : per_cnt + ONE;
            if (cap1) ph1_width <= seg_cnt;
            if (cap2) ph2_width <= seg_cnt;
            if (done) period <= per_cnt;
            if (set_ov || set_seq || set_wid) begin
                lock_cnt <= '0;
            end else if (done && (lock_cnt != LOCK_N)) begin
                lock_cnt <= lock_cnt + LC_W'(1);
            end
            // A new error in the same cycle as err_clr keeps its flag set.
            overlap_err <= set_ov  | (overlap_err & ~bus.err_clr);
            seq_err     <= set_seq | (seq_err     & ~bus.err_clr);
            width_err   <= set_wid | (width_err   & ~bus.err_clr);
        end
    end

    assign bus.ph1_rise    = str_r1;
    assign bus.ph1_fall    = str_f1;
    assign bus.ph2_rise    = str_r2;
    assign bus.ph2_fall    = str_f2;
    assign bus.ph1_width   = ph1_width;
    assign bus.ph2_width   = ph2_width;
    assign bus.period      = period;
    assign bus.locked      = (lock_cnt == LOCK_N);
    assign bus.overlap_err = overlap_err;
    assign bus.seq_err     = seq_err;
    assign bus.width_err   = width_err;
    assign bus.state       = state;

endmodule

// File: tb/tb_phase_monitor.sv
// Self-checking bench for phase_monitor: waveform table, directed corner cases, random cycles.
module tb_phase_monitor;
  import phase_mon_pkg::*;

  localparam int MINH = 16;

  typedef struct {
    int     w1, g1, w2, g2, reps;
    int     ph1, ph2, per;
    int     lk, werr;
    state_t st;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  phase_monitor_if #(.CNT_W(9)) bus ();

  phase_monitor #(.CNT_W(9), .MIN_HIGH(MINH), .LOCK_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Leaves time just after a rising edge, so checks here are away from the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.phi_1 = 1'b0;
    bus.phi_2 = 1'b0;
    bus.err_clr = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic drive_cycle(input int w1, input int g1, input int w2, input int g2);
    bus.phi_1 = 1'b1; tick(w1);
    bus.phi_1 = 1'b0; tick(g1);
    bus.phi_2 = 1'b1; tick(w2);
    bus.phi_2 = 1'b0; tick(g2);
  endtask

  task automatic check_all(input string tag, input int ph1, input int ph2, input int per,
                           input int lk, input int ov, input int sq, input int we,
                           input state_t st);
    check({tag, ".ph1_width"}, int'(bus.ph1_width), ph1);
    check({tag, ".ph2_width"}, int'(bus.ph2_width), ph2);
    check({tag, ".period"}, int'(bus.period), per);
    check({tag, ".locked"}, int'(bus.locked), lk);
    check({tag, ".overlap_err"}, int'(bus.overlap_err), ov);
    check({tag, ".seq_err"}, int'(bus.seq_err), sq);
    check({tag, ".width_err"}, int'(bus.width_err), we);
    check({tag, ".state"}, int'(bus.state), int'(st));
  endtask

  initial begin
    vec_t vecs[7];
    int   cnt_r, cnt_f;
    int   m_ph1, m_ph2, m_per, m_lock, m_werr, prev_total;
    bit   prev_ok;
    int   w1, g1, w2, g2;

    vecs[0] = '{100, 100, 100, 200, 5, 100, 100, 500, 1, 0, GAP21};
    vecs[1] = '{100, 100, 100, 200, 4, 100, 100, 500, 0, 0, GAP21};
    vecs[2] = '{16, 3, 16, 3, 6, 16, 16, 38, 1, 0, GAP21};
    vecs[3] = '{15, 5, 20, 5, 3, 15, 0, 0, 0, 1, HUNT};
    vecs[4] = '{20, 5, 15, 5, 3, 20, 15, 0, 0, 1, HUNT};
    vecs[5] = '{30, 4, 40, 6, 2, 30, 40, 80, 0, 0, GAP21};
    vecs[6] = '{600, 5, 20, 5, 2, 511, 20, 511, 0, 0, GAP21};

    // Reset values while rst_n is still low
    bus.phi_1 = 1'b0;
    bus.phi_2 = 1'b0;
    bus.err_clr = 1'b0;
    tick(2);
    check_all("reset", 0, 0, 0, 0, 0, 0, 0, HUNT);
    check("reset.strobes", int'({bus.ph1_rise, bus.ph1_fall, bus.ph2_rise, bus.ph2_fall}), 0);
    rst_n = 1'b1;
    tick(2);

    // Strobe latency: change after edge N, strobe visible only after edge N+2
    bus.phi_1 = 1'b1;
    tick(1); check("strobe.n1", int'(bus.ph1_rise), 0);
    tick(1); check("strobe.n2", int'(bus.ph1_rise), 1);
    check("strobe.state", int'(bus.state), int'(P1_HIGH));
    tick(1); check("strobe.n3", int'(bus.ph1_rise), 0);

    // Table of steady waveforms
    for (int i = 0; i < 7; i++) begin
      do_reset();
      for (int r = 0; r < vecs[i].reps; r++)
        drive_cycle(vecs[i].w1, vecs[i].g1, vecs[i].w2, vecs[i].g2);
      check_all($sformatf("vec%0d", i), vecs[i].ph1, vecs[i].ph2, vecs[i].per,
                vecs[i].lk, 0, 0, vecs[i].werr, vecs[i].st);
    end

    // Two phi_1 pulses with no phi_2 between them
    do_reset();
    bus.phi_1 = 1'b1; tick(20);
    bus.phi_1 = 1'b0; tick(5);
    bus.phi_1 = 1'b1; tick(4);
    check_all("seq", 20, 0, 0, 0, 0, 1, 0, HUNT);
    tick(16);
    bus.phi_1 = 1'b0; tick(10);

    // Lock, then phi_2 forced high for 3 clk inside phi_1 high
    for (int k = 0; k < 5; k++) drive_cycle(20, 5, 20, 10);
    check("ovl.pre_locked", int'(bus.locked), 1);
    bus.phi_1 = 1'b1; tick(5);
    bus.phi_2 = 1'b1; tick(3);
    bus.phi_2 = 1'b0; tick(5);
    bus.phi_1 = 1'b0; tick(10);
    check_all("ovl", 20, 20, 55, 0, 1, 1, 0, HUNT);
    for (int k = 0; k < 4; k++) drive_cycle(20, 5, 20, 10);
    check("relock.after4", int'(bus.locked), 0);
    drive_cycle(20, 5, 20, 10);
    check("relock.after5", int'(bus.locked), 1);

    // err_clr lands on the last overlapping sample: the error must win
    bus.phi_1 = 1'b1; bus.phi_2 = 1'b1; tick(3);
    bus.phi_1 = 1'b0; bus.phi_2 = 1'b0; bus.err_clr = 1'b1; tick(1);
    bus.err_clr = 1'b0; tick(3);
    check("clr_vs_err.overlap_err", int'(bus.overlap_err), 1);
    check("clr_vs_err.locked", int'(bus.locked), 0);
    bus.err_clr = 1'b1; tick(1);
    bus.err_clr = 1'b0; tick(2);
    check("clr.overlap_err", int'(bus.overlap_err), 0);
    check("clr.seq_err", int'(bus.seq_err), 0);
    check("clr.width_err", int'(bus.width_err), 0);

    // Asynchronous reset in the middle of P2_HIGH
    do_reset();
    bus.phi_1 = 1'b1; tick(20);
    bus.phi_1 = 1'b0; tick(5);
    bus.phi_2 = 1'b1; tick(10);
    check("rstmid.pre_state", int'(bus.state), int'(P2_HIGH));
    #2 rst_n = 1'b0;
    #1 check_all("rstmid", 0, 0, 0, 0, 0, 0, 0, HUNT);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt_r = 0;
    cnt_f = 0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      cnt_r += int'(bus.ph2_rise);
    end
    bus.phi_2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      cnt_f += int'(bus.ph2_fall);
    end
    check("rstmid.ph2_rise_count", cnt_r, 0);
    check("rstmid.ph2_fall_count", cnt_f, 1);
    check_all("rstmid.after", 0, 0, 0, 0, 0, 0, 0, HUNT);

    // Random cycles against a cycle-level model of the expected measurements
    do_reset();
    m_ph1 = 0; m_ph2 = 0; m_per = 0; m_lock = 0; m_werr = 0;
    prev_ok = 1'b0;
    prev_total = 0;
    for (int c = 0; c < 30; c++) begin
      w1 = ($urandom_range(0, 5) == 0) ? $urandom_range(10, MINH - 1) : $urandom_range(MINH, 60);
      w2 = ($urandom_range(0, 5) == 0) ? $urandom_range(10, MINH - 1) : $urandom_range(MINH, 60);
      g1 = $urandom_range(3, 20);
      g2 = $urandom_range(3, 20);
      if (prev_ok) begin
        m_per = prev_total;
        m_lock = (m_lock < 4) ? m_lock + 1 : 4;
      end
      m_ph1 = w1;
      if (w1 < MINH) begin
        m_werr = 1;
        m_lock = 0;
        prev_ok = 1'b0;
      end else begin
        m_ph2 = w2;
        prev_ok = (w2 >= MINH);
        if (w2 < MINH) begin
          m_werr = 1;
          m_lock = 0;
        end
      end
      prev_total = w1 + g1 + w2 + g2;
      drive_cycle(w1, g1, w2, g2);
      check_all($sformatf("rnd%0d", c), m_ph1, m_ph2, m_per, int'(m_lock == 4), 0, 0, m_werr,
                prev_ok ? GAP21 : HUNT);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
